xnor_scoreboard: RTL and testbench
==================================

Name: xnor_scoreboard

Overview:
- Downstream checking stage for the single-bit XNOR datapath (z = ~(x ^ y)). Consumes the reference and DUT outputs once per sample strobe.
- Accumulates sample, mismatch and first-mismatch statistics over a programmed run.
- Signals pass/fail at run end. Lets the check run in hardware or emulation without a behavioural bench.

Parameters:
- NUM_SAMPLES, 108, samples accepted per run before DONE (4 directed + 104 random); legal range 1..2^CNT_W-1.
- CNT_W, 16, width of sample and error counters.
- TIME_W, 32, width of free-running run-cycle timestamp.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- sample_en  input  1  current z_ref/z_dut pair is a valid sample.
- ref_known  input  1  z_ref is defined; 0 = don't-care sample (counted, never a mismatch).
- z_ref  input  1  reference output.
- z_dut  input  1  DUT output.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff errors == 0.
- samples  output  CNT_W  samples accepted this run.
- errors  output  CNT_W  mismatches this run; saturates at all-ones.
- first_err_valid  output  1  at least one mismatch recorded this run.
- first_err_cycle  output  TIME_W  run-cycle timestamp of first mismatch.

Behaviour:
- Reset (resetn=0 at a clock edge): state IDLE; busy=0, done=0, pass=0, samples=0, errors=0, first_err_valid=0, first_err_cycle=0, run_cycle=0.
- Reset overrides every input, including mid-run; the partial run is discarded.
- All outputs are registered.
- mismatch = sample_en & ref_known & (z_ref != z_dut), evaluated combinationally. Its effect is visible on the outputs one cycle later.
- State IDLE:
  - start=1: clear all counters and flags, go to RUN.
  - Otherwise hold.
- State RUN:
  - run_cycle increments every cycle; it is 0 in the first RUN cycle and wraps modulo 2^TIME_W.
  - sample_en=1: samples += 1.
  - mismatch=1: errors += 1, unless errors is all-ones, in which case it holds.
  - mismatch=1 and first_err_valid=0: set first_err_valid=1 and first_err_cycle=run_cycle of that cycle.
  - start is ignored in RUN.
  - Accepting the sample that makes samples == NUM_SAMPLES: go to DONE on the same edge.
    - That final sample is still counted and checked.
    - busy falls and done rises on the same edge.
  - Samples with sample_en=0 or ref_known=0 never change errors.
- State DONE:
  - All statistics hold.
  - pass = (errors == 0); pass is registered on entry to DONE and held.
  - sample_en is ignored.
  - start=1: clear statistics, go to RUN (restart).
- start and sample_en in the same cycle in IDLE/DONE: start takes effect; that sample is not counted.
- A counter never wraps: samples stops at NUM_SAMPLES by construction.

Test Plan:
- Reset, then start, then 4 directed samples (x,y) = 00, 01, 10, 11 with z_dut = z_ref = 1, 0, 0, 1, then 104 matching random samples -> done=1 exactly one cycle after the 108th sample edge; samples=108, errors=0, pass=1, first_err_valid=0.
- Run with z_dut forced 0 from sample 3 onward and sample_en every cycle -> first_err_cycle=2, first_err_valid=1, pass=0. errors equals the count of samples from index 2 onward where z_ref=1.
- Run with ref_known=0 on every sample and z_dut opposite to z_ref -> errors=0, pass=1, samples=108.
- Pulse resetn=0 for one cycle after 50 samples -> next cycle busy=0, done=0, samples=0, errors=0. A subsequent start runs a clean full run to samples=108.
- Sparse sample_en (every 3rd cycle), with a start pulse mid-run and another start pulse in DONE -> the mid-run start is ignored. The DONE start clears samples/errors to 0, busy=1 on the next cycle.
- CNT_W=4, NUM_SAMPLES=15, all samples mismatching -> errors reaches 15 (all-ones) and stays there; done after sample 15; pass=0.

Source files
------------

// File: rtl/xnor_scoreboard.sv
// Run-level checker for the single-bit XNOR datapath: counts samples and
// reference/DUT mismatches over a programmed run and reports pass at run end.
module xnor_scoreboard #(
  parameter int NUM_SAMPLES = 108,
  parameter int CNT_W       = 16,
  parameter int TIME_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              sample_en,
  input  logic              ref_known,
  input  logic              z_ref,
  input  logic              z_dut,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  samples,
  output logic [CNT_W-1:0]  errors,
  output logic              first_err_valid,
  output logic [TIME_W-1:0] first_err_cycle
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [TIME_W-1:0] run_cycle;
  logic              mismatch;
  logic              last;
  logic [CNT_W-1:0]  err_next;

  assign mismatch = sample_en & ref_known & (z_ref != z_dut);
  assign last     = sample_en && (samples == CNT_W'(NUM_SAMPLES - 1));

  // Error count saturates; pass on the final edge must see the final sample.
  always_comb begin
    err_next = errors;
    if (mismatch && (errors != {CNT_W{1'b1}}))
      err_next = errors + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      samples         <= '0;
      errors          <= '0;
      first_err_valid <= 1'b0;
      first_err_cycle <= '0;
      run_cycle       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= RUN;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            samples         <= '0;
            errors          <= '0;
            first_err_valid <= 1'b0;
            first_err_cycle <= '0;
            run_cycle       <= '0;
          end
        end
        RUN: begin
          run_cycle <= run_cycle + 1'b1;
          errors    <= err_next;
          if (sample_en)
            samples <= samples + 1'b1;
          if (mismatch && !first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_cycle <= run_cycle;
          end
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_scoreboard.sv
// Directed bench for xnor_scoreboard: table-driven opening samples plus
// hand-written multi-cycle runs (errors, don't-care, reset, restart, small counter).
module tb_xnor_scoreboard;

  logic        clk = 1'b0;
  logic        resetn, start, start2, sample_en, ref_known, z_ref, z_dut;
  logic        busy, done, pass, first_err_valid;
  logic [15:0] samples, errors;
  logic [31:0] first_err_cycle;
  logic        busy2, done2, pass2, fev2;
  logic [3:0]  samples2, errors2;
  logic [31:0] fec2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  xnor_scoreboard dut (
    .clk(clk), .resetn(resetn), .start(start), .sample_en(sample_en),
    .ref_known(ref_known), .z_ref(z_ref), .z_dut(z_dut),
    .busy(busy), .done(done), .pass(pass), .samples(samples), .errors(errors),
    .first_err_valid(first_err_valid), .first_err_cycle(first_err_cycle)
  );

  xnor_scoreboard #(.NUM_SAMPLES(15), .CNT_W(4), .TIME_W(32)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .sample_en(sample_en),
    .ref_known(ref_known), .z_ref(z_ref), .z_dut(z_dut),
    .busy(busy2), .done(done2), .pass(pass2), .samples(samples2), .errors(errors2),
    .first_err_valid(fev2), .first_err_cycle(fec2)
  );

  typedef struct {
    logic en, known, r, d;
    int   exp_s, exp_e;
    logic exp_fev;
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic smp(input logic en, input logic known, input logic r, input logic d);
    sample_en = en; ref_known = known; z_ref = r; z_dut = d;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1; sample_en = 1'b0;
    tick();
    start = 1'b0;
  endtask

  function automatic logic rand_ref();
    logic x, y;
    x = 1'($urandom_range(0, 1));
    y = 1'($urandom_range(0, 1));
    return ~(x ^ y);
  endfunction

  initial begin
    int   exp_e;
    logic r;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 0, 1'b0}; // x,y = 00
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0}; // 01
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0}; // 10
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4, 0, 1'b0}; // 11
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4, 0, 1'b0}; // disabled sample, values differ
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 5, 0, 1'b0}; // don't-care, values differ

    resetn = 1'b0; start = 1'b0; start2 = 1'b0;
    sample_en = 1'b0; ref_known = 1'b1; z_ref = 1'b0; z_dut = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_samples", samples, 0);
    chk("rst_errors", errors, 0);
    chk("rst_fev", first_err_valid, 0);
    chk("rst_fec", first_err_cycle, 0);
    resetn = 1'b1;
    tick();
    chk("idle_hold_busy", busy, 0);

    // Run 1: all matching.
    do_start();
    chk("r1_busy", busy, 1);
    chk("r1_samples0", samples, 0);
    for (int i = 0; i < 6; i++) begin
      smp(tbl[i].en, tbl[i].known, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d_samples", i), samples, tbl[i].exp_s);
      chk($sformatf("tbl%0d_errors", i), errors, tbl[i].exp_e);
      chk($sformatf("tbl%0d_fev", i), first_err_valid, tbl[i].exp_fev);
    end
    for (int i = 5; i < 107; i++) begin
      r = rand_ref();
      smp(1'b1, 1'b1, r, r);
    end
    chk("r1_pre_done", done, 0);
    chk("r1_pre_busy", busy, 1);
    r = rand_ref();
    smp(1'b1, 1'b1, r, r);
    sample_en = 1'b0;
    chk("r1_done", done, 1);
    chk("r1_busy_end", busy, 0);
    chk("r1_samples", samples, 108);
    chk("r1_errors", errors, 0);
    chk("r1_pass", pass, 1);
    chk("r1_fev", first_err_valid, 0);

    // Run 2: z_dut stuck at 0 from the third sample on.
    do_start();
    chk("r2_clr_samples", samples, 0);
    chk("r2_busy", busy, 1);
    chk("r2_done", done, 0);
    exp_e = 0;
    for (int i = 0; i < 108; i++) begin
      r = (i == 2) ? 1'b1 : rand_ref();
      if (i >= 2 && r) exp_e++;
      smp(1'b1, 1'b1, r, (i >= 2) ? 1'b0 : r);
    end
    sample_en = 1'b0;
    chk("r2_done", done, 1);
    chk("r2_fev", first_err_valid, 1);
    chk("r2_fec", first_err_cycle, 2);
    chk("r2_errors", errors, exp_e);
    chk("r2_pass", pass, 0);

    // Run 3: every reference is don't-care and disagrees.
    do_start();
    for (int i = 0; i < 108; i++) begin
      r = rand_ref();
      smp(1'b1, 1'b0, r, ~r);
    end
    sample_en = 1'b0;
    chk("r3_errors", errors, 0);
    chk("r3_pass", pass, 1);
    chk("r3_samples", samples, 108);
    chk("r3_done", done, 1);

    // Run 4: reset mid-run, then a clean run.
    do_start();
    for (int i = 0; i < 50; i++) smp(1'b1, 1'b1, 1'b1, 1'b0);
    chk("r4_mid_samples", samples, 50);
    resetn = 1'b0;
    tick();
    resetn = 1'b1; sample_en = 1'b0;
    chk("r4_rst_busy", busy, 0);
    chk("r4_rst_done", done, 0);
    chk("r4_rst_samples", samples, 0);
    chk("r4_rst_errors", errors, 0);
    chk("r4_rst_fev", first_err_valid, 0);
    do_start();
    for (int i = 0; i < 108; i++) begin
      r = rand_ref();
      smp(1'b1, 1'b1, r, r);
    end
    sample_en = 1'b0;
    chk("r4_samples", samples, 108);
    chk("r4_pass", pass, 1);
    chk("r4_done", done, 1);

    // Run 5: sparse samples, start ignored mid-run, restart from DONE.
    do_start();
    for (int c = 0; c < 324; c++) begin
      start = (c == 30);
      smp((c % 3) == 2, 1'b1, 1'b1, 1'b1);
      if (c == 30) begin
        chk("r5_midstart_busy", busy, 1);
        chk("r5_midstart_samples", samples, 10);
      end
    end
    start = 1'b0;
    chk("r5_done", done, 1);
    chk("r5_samples", samples, 108);
    smp(1'b1, 1'b1, 1'b1, 1'b0);
    chk("r5_done_ignore_samples", samples, 108);
    chk("r5_done_ignore_errors", errors, 0);
    start = 1'b1;
    smp(1'b1, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    chk("r5_restart_samples", samples, 0);
    chk("r5_restart_errors", errors, 0);
    chk("r5_restart_busy", busy, 1);
    chk("r5_restart_done", done, 0);
    smp(1'b1, 1'b1, 1'b1, 1'b0);
    sample_en = 1'b0;
    chk("r5_first_samples", samples, 1);
    chk("r5_first_errors", errors, 1);
    chk("r5_first_fec", first_err_cycle, 0);

    // Run 6: 4-bit counters, every sample mismatching.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    start2 = 1'b1; sample_en = 1'b0;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 14; i++) smp(1'b1, 1'b1, 1'b0, 1'b1);
    chk("r6_errors14", errors2, 14);
    chk("r6_busy14", busy2, 1);
    smp(1'b1, 1'b1, 1'b0, 1'b1);
    chk("r6_errors15", errors2, 15);
    chk("r6_done", done2, 1);
    chk("r6_samples", samples2, 15);
    chk("r6_pass", pass2, 0);
    smp(1'b1, 1'b1, 1'b0, 1'b1);
    sample_en = 1'b0;
    chk("r6_errors_hold", errors2, 15);
    chk("r6_samples_hold", samples2, 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
